// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, plus MTHI/MTLO writes.
// Optional Div_Zero result flag is enabled by defining MDU_DIVZERO_FLAG_EN.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HI_WE,
  input  logic             LO_WE,
  input  logic [WIDTH-1:0] Write_Data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             Div_Zero
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [1:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] oper_q, oper_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MDU_DIVZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes, one iteration step and the final sign correction.
  always_comb begin
    signed_op = ~Op[0];
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_abs     = a_neg ? (-A) : A;
    b_abs     = b_neg ? (-B) : B;

    // Multiply: conditional add of the multiplicand into the upper half, then shift right.
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, oper_q} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, oper_q};

    prod      = {work_hi_q, work_lo_q};
    prod_fix  = (neg_a_q ^ neg_b_q) ? (-prod) : prod;
    quo_fix   = (neg_a_q ^ neg_b_q) ? (-work_lo_q) : work_lo_q;
    rem_fix   = neg_a_q ? (-work_hi_q) : work_hi_q;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    b_zero_d  = b_zero_q;
    oper_d    = oper_q;
    a_raw_d   = a_raw_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
    dz_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_RUN;
          counter_d = {CW{1'b0}};
          op_d      = Op;
          neg_a_d   = a_neg;
          neg_b_d   = b_neg;
          b_zero_d  = (B == {WIDTH{1'b0}});
          a_raw_d   = A;
          work_hi_d = {WIDTH{1'b0}};
          busy_d    = 1'b1;
          if (Op[1]) begin
            oper_d    = b_abs;
            work_lo_d = a_abs;
          end else begin
            oper_d    = a_abs;
            work_lo_d = b_abs;
          end
        end else begin
          busy_d = 1'b0;
          if (HI_WE) begin
            hi_d = Write_Data;
          end else begin
            hi_d = hi_q;
          end
          if (LO_WE) begin
            lo_d = Write_Data;
          end else begin
            lo_d = lo_q;
          end
        end
      end

      S_RUN: begin
        busy_d    = 1'b1;
        counter_d = counter_q + {{(CW-1){1'b0}}, 1'b1};
        if (op_q[1]) begin
          if (div_diff[WIDTH] == 1'b0) begin
            work_hi_d = div_diff[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            work_hi_d = div_shift[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          work_hi_d = mul_sum[WIDTH:1];
          work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
        if (counter_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (op_q[1]) begin
          // A zero divisor reports the raw dividend, bypassing sign correction.
          if (b_zero_q) begin
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
`ifdef MDU_DIVZERO_FLAG_EN
          dz_d = b_zero_q;
`endif
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      counter_q <= {CW{1'b0}};
      op_q      <= 2'b00;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      oper_q    <= {WIDTH{1'b0}};
      a_raw_q   <= {WIDTH{1'b0}};
      work_hi_q <= {WIDTH{1'b0}};
      work_lo_q <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      b_zero_q  <= b_zero_d;
      oper_q    <= oper_d;
      a_raw_q   <= a_raw_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  assign Div_Zero = dz_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops against a 64-bit arithmetic model.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        HI_WE = 1'b0;
  logic        LO_WE = 1'b0;
  logic [31:0] Write_Data = 32'h0;
  logic        Busy, Done;
  logic [31:0] HI, LO;
`ifdef MDU_DIVZERO_FLAG_EN
  logic        Div_Zero;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI_WE(HI_WE), .LO_WE(LO_WE), .Write_Data(Write_Data),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
`ifdef MDU_DIVZERO_FLAG_EN
    , .Div_Zero(Div_Zero)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib, q, rm;
    longint sa, sb, p;
    logic [63:0] ua, ub;
    ia = a; ib = b;
    case (op)
      2'b00: begin sa = ia; sb = ib; p = sa * sb; return 64'(p); end
      2'b01: begin ua = {32'h0, a}; ub = {32'h0, b}; return ua * ub; end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = ia / ib; rm = ia % ib;
        return {32'(rm), 32'(q)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_with_start, input string tag);
    logic [63:0] e;
    int n;
    e = ref_model(op, a, b);
    @(negedge CLK);
    Start = 1'b1; Op = op; A = a; B = b;
    HI_WE = mt_with_start; Write_Data = 32'h12345678;
    @(posedge CLK); #1;
    Start = 1'b0; HI_WE = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom);
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      if (n == 0 || n == 32) check({tag, "_busy"}, {63'h0, Busy}, 64'h1);
      if (n == 16) check({tag, "_hold"}, {HI, LO}, {exp_hi, exp_lo});
      if (disturb && n == 5) begin Start = 1'b1; HI_WE = 1'b1; Write_Data = 32'h12345678; end
      if (disturb && n == 6) begin Start = 1'b0; HI_WE = 1'b0; end
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_result"}, {HI, LO}, e);
    check({tag, "_busy_done"}, {63'h0, Busy}, 64'h0);
`ifdef MDU_DIVZERO_FLAG_EN
    check({tag, "_divzero"}, {63'h0, Div_Zero}, {63'h0, (op[1] && b == 32'h0)});
`endif
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    if (disturb) begin
      @(posedge CLK); #1;
      check({tag, "_single_done"}, {62'h0, Done, Busy}, 64'h0);
    end
  endtask

  task automatic mt_write(input logic we_hi, input logic we_lo, input logic [31:0] data, input string tag);
    @(negedge CLK);
    HI_WE = we_hi; LO_WE = we_lo; Write_Data = data;
    @(posedge CLK); #1;
    HI_WE = 1'b0; LO_WE = 1'b0;
    if (we_hi) exp_hi = data;
    if (we_lo) exp_lo = data;
    check(tag, {HI, LO}, {exp_hi, exp_lo});
  endtask

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset_hilo", {HI, LO}, 64'h0);
    check("reset_ctrl", {62'h0, Busy, Done}, 64'h0);

    run_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0, "mult_neg");
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu_max");
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, "div_neg");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    run_op(2'b11, 32'h00000005, 32'h00000000, 1'b0, 1'b0, "divu_zero");
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000000, 1'b0, 1'b0, "div_zero");
    run_op(2'b00, 32'h00001234, 32'h00005678, 1'b1, 1'b0, "busy_disturb");
    mt_write(1'b1, 1'b0, 32'h12345678, "mthi_idle");
    mt_write(1'b0, 1'b1, 32'hCAFEF00D, "mtlo_idle");
    mt_write(1'b1, 1'b1, 32'h0BADBEEF, "mt_both");
    run_op(2'b01, 32'h00000007, 32'h00000009, 1'b0, 1'b1, "start_with_mthi");

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      run_op(rop, ra, rb, 1'b0, 1'b0, "rand");
      if ($urandom_range(0, 4) == 0) mt_write(1'($urandom), 1'($urandom), $urandom, "rand_mt");
    end

    // Reset in the middle of a MULTU must abort with no Done afterwards.
    @(negedge CLK);
    Start = 1'b1; Op = 2'b01; A = 32'hDEADBEEF; B = 32'h12345678;
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("midrun_reset_hilo", {HI, LO}, 64'h0);
    check("midrun_reset_ctrl", {62'h0, Busy, Done}, 64'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done === 1'b1) dones++;
    end
    check("midrun_no_done", 64'(dones), 64'd0);
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
